// File: rtl/phv_queue_dispatch_if.sv
// Valid/ready stream bundle for the PHV dispatcher: one shared data bus with
// one valid/ready pair per lane (1 lane upstream, one lane per queue downstream).
interface phv_queue_dispatch_if #(
    parameter int DATA_W = 1024,
    parameter int LANES  = 1
) ();
    // A lane transfers on a cycle where its valid and ready are both high;
    // once valid is raised, valid and data hold until that transfer happens.
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  valid;
    logic [LANES-1:0]  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/phv_queue_dispatch.sv
// Holds each PHV until every queue in its bitmap has taken it; zero-bitmap PHVs are dropped.
// Optional statistics counters are built only when PHV_DISPATCH_STATS_EN is defined.
module phv_queue_dispatch #(
    parameter int PHV_LEN      = 1024,
    parameter int C_NUM_QUEUES = 4,
    parameter int QUEUE_OFF    = 141,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                              axis_clk,
    input  logic                              reset,
    phv_queue_dispatch_if.slave               phv_in_if,
    phv_queue_dispatch_if.master              phv_out_if,
    output logic                              busy,
    output logic [CNT_WIDTH-1:0]              drop_cnt,
    output logic [C_NUM_QUEUES*CNT_WIDTH-1:0] sent_cnt
);

    generate
        if (QUEUE_OFF + C_NUM_QUEUES > PHV_LEN) begin : g_bad_offset
            $error("phv_queue_dispatch: queue bitmap exceeds PHV_LEN");
        end
        if (C_NUM_QUEUES < 1 || C_NUM_QUEUES > 16) begin : g_bad_queues
            $error("phv_queue_dispatch: C_NUM_QUEUES must be 1..16");
        end
    endgenerate

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]              state_r;
    logic                    rdy_en_r;
    logic [PHV_LEN-1:0]      phv_r;
    logic [C_NUM_QUEUES-1:0] pend_r;

    logic                    hold;
    logic [C_NUM_QUEUES-1:0] bitmap;
    logic [C_NUM_QUEUES-1:0] out_valid;
    logic [C_NUM_QUEUES-1:0] deliver;
    logic [C_NUM_QUEUES-1:0] remaining;
    logic                    in_ready;
    logic                    accept;
    logic                    accept_hit;

    always_comb begin
        hold       = (state_r == ST_HOLD);
        bitmap     = phv_in_if.data[QUEUE_OFF +: C_NUM_QUEUES];
        out_valid  = hold ? pend_r : '0;
        deliver    = out_valid & phv_out_if.ready;
        remaining  = pend_r & ~deliver;
        // rdy_en_r keeps ready low through reset and until the first edge after it.
        in_ready   = rdy_en_r & (~hold | (remaining == '0));
        accept     = phv_in_if.valid[0] & in_ready;
        accept_hit = accept & (bitmap != '0);
    end

    assign phv_in_if.ready[0] = in_ready;
    assign phv_out_if.data    = phv_r;
    assign phv_out_if.valid   = out_valid;
    assign busy               = hold;

    always_ff @(posedge axis_clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            rdy_en_r <= 1'b0;
            phv_r    <= '0;
            pend_r   <= '0;
        end else begin
            rdy_en_r <= 1'b1;
            if (accept_hit) begin
                // A same-cycle accept on HOLD exit reloads without a bubble.
                state_r <= ST_HOLD;
                phv_r   <= phv_in_if.data;
                pend_r  <= bitmap;
            end else if (hold) begin
                pend_r <= remaining;
                if (remaining == '0) begin
                    state_r <= ST_IDLE;
                end
            end
        end
    end

`ifdef PHV_DISPATCH_STATS_EN
    logic                 drop_evt;
    logic [CNT_WIDTH-1:0] drop_r;
    logic [CNT_WIDTH-1:0] sent_r [C_NUM_QUEUES];

    assign drop_evt = accept & (bitmap == '0);

    always_ff @(posedge axis_clk or posedge reset) begin
        if (reset) begin
            drop_r <= '0;
            for (int i = 0; i < C_NUM_QUEUES; i++) begin
                sent_r[i] <= '0;
            end
        end else begin
            // Counters saturate at all-ones rather than wrapping.
            if (drop_evt && (drop_r != {CNT_WIDTH{1'b1}})) begin
                drop_r <= drop_r + CNT_WIDTH'(1);
            end
            for (int i = 0; i < C_NUM_QUEUES; i++) begin
                if (deliver[i] && (sent_r[i] != {CNT_WIDTH{1'b1}})) begin
                    sent_r[i] <= sent_r[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        drop_cnt = drop_r;
        sent_cnt = '0;
        for (int i = 0; i < C_NUM_QUEUES; i++) begin
            sent_cnt[i*CNT_WIDTH +: CNT_WIDTH] = sent_r[i];
        end
    end
`else
    assign drop_cnt = '0;
    assign sent_cnt = '0;
`endif

endmodule

// File: tb/tb_phv_queue_dispatch.sv
// Randomised bench for phv_queue_dispatch: directed scenarios plus a random run,
// checked against a transaction-level model and per-queue delivery queues.
module tb_phv_queue_dispatch;
    localparam int W    = 256;
    localparam int NQ   = 4;
    localparam int QOFF = 141;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PHV_DISPATCH_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic             axis_clk = 1'b0;
    logic             reset = 1'b1;
    logic             busy;
    logic [CW-1:0]    drop_cnt;
    logic [NQ*CW-1:0] sent_cnt;

    phv_queue_dispatch_if #(.DATA_W(W), .LANES(1))  in_if ();
    phv_queue_dispatch_if #(.DATA_W(W), .LANES(NQ)) out_if ();

    phv_queue_dispatch #(
        .PHV_LEN(W), .C_NUM_QUEUES(NQ), .QUEUE_OFF(QOFF), .CNT_WIDTH(CW)
    ) u_dut (
        .axis_clk   (axis_clk),
        .reset      (reset),
        .phv_in_if  (in_if),
        .phv_out_if (out_if),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .sent_cnt   (sent_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the PHV being held, which queues still owe it, and stats.
    bit            m_busy;
    bit            m_live;
    logic [W-1:0]  m_phv;
    logic [NQ-1:0] m_pend;
    int            m_sent [NQ];
    int            m_drop;
    logic [W-1:0]  exp_q [NQ][$];

    logic          exp_in_ready, obs_in_ready;
    logic [NQ-1:0] exp_valid, obs_valid;
    logic [W-1:0]  exp_out, obs_out;
    logic          exp_busy, obs_busy;

    task automatic model_reset();
        m_busy = 0; m_live = 0; m_phv = '0; m_pend = '0; m_drop = 0;
        for (int i = 0; i < NQ; i++) begin
            m_sent[i] = 0;
            exp_q[i].delete();
        end
    endtask

    function automatic logic [W-1:0] make_phv(input logic [NQ-1:0] m);
        logic [W-1:0] p;
        for (int i = 0; i < W/32; i++) p[i*32 +: 32] = $urandom;
        p[QOFF +: NQ] = m;
        return p;
    endfunction

    function automatic int exp_cnt(input int v);
        return STATS_ON ? v : 0;
    endfunction

    // Called at posedge+1: drive, sample at negedge, then advance the model past the edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic [NQ-1:0] r);
        logic [NQ-1:0] m;
        in_if.valid[0] = v; in_if.data = d; out_if.ready = r;
        @(negedge axis_clk);
        exp_valid    = m_busy ? m_pend : '0;
        exp_in_ready = m_live && (!m_busy || ((m_pend & ~r) == '0));
        exp_out      = m_phv;
        exp_busy     = m_busy;
        obs_in_ready = in_if.ready[0];
        obs_valid    = out_if.valid;
        obs_out      = out_if.data;
        obs_busy     = busy;
        @(posedge axis_clk);
        #1;
        for (int i = 0; i < NQ; i++)
            if (exp_valid[i] && r[i] && m_sent[i] < CMAX) m_sent[i]++;
        m = d[QOFF +: NQ];
        if (v && exp_in_ready && m == '0) begin
            if (m_drop < CMAX) m_drop++;
        end
        if (v && exp_in_ready && m != '0) begin
            for (int i = 0; i < NQ; i++) if (m[i]) exp_q[i].push_back(d);
            m_busy = 1; m_phv = d; m_pend = m;
        end else if (m_busy) begin
            m_pend = m_pend & ~r;
            if (m_pend == '0) m_busy = 0;
        end
        m_live = 1;
    endtask

    // Scoreboard: every delivery on queue i must be the oldest PHV still owed to i.
    always @(negedge axis_clk) begin
        if (!reset) begin
            for (int i = 0; i < NQ; i++) begin
                if (out_if.valid[i] && out_if.ready[i]) begin
                    total++;
                    if (exp_q[i].size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected q%0d act=%h exp=none", i, out_if.data);
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q[i].pop_front();
                        if (out_if.data !== e) begin
                            bad++;
                            $display("FAIL sb_data q%0d act=%h exp=%h", i, out_if.data, e);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        model_reset();
        in_if.valid[0] = 0; in_if.data = '0; out_if.ready = '1;
        repeat (2) @(posedge axis_clk);
        @(negedge axis_clk);
        total++; if (in_if.ready[0] !== 1'b0) begin bad++; $display("FAIL rst_in_ready act=%b exp=0", in_if.ready[0]); end
        total++; if (out_if.valid !== '0) begin bad++; $display("FAIL rst_valid act=%b exp=0", out_if.valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy act=%b exp=0", busy); end
        total++; if (drop_cnt !== '0 || sent_cnt !== '0) begin bad++; $display("FAIL rst_cnt act=%h/%h exp=0", drop_cnt, sent_cnt); end
        total++; if (out_if.data !== '0) begin bad++; $display("FAIL rst_phv act=%h exp=0", out_if.data); end
        reset = 0;
        #1;
        total++; if (in_if.ready[0] !== 1'b0) begin bad++; $display("FAIL rst_rel_ready act=%b exp=0", in_if.ready[0]); end
        @(posedge axis_clk); #1;
        m_live = 1;
        total++; if (in_if.ready[0] !== 1'b1) begin bad++; $display("FAIL rst_first_edge act=%b exp=1", in_if.ready[0]); end
    endtask

    task automatic test_unicast();
        int s0 [NQ];
        logic [NQ-1:0] ev;
        for (int i = 0; i < NQ; i++) s0[i] = m_sent[i];
        for (int k = 0; k <= 8; k++) begin
            cycle(k < 8, make_phv(NQ'(1 << (k % NQ))), '1);
            ev = (k == 0) ? '0 : NQ'(1 << ((k - 1) % NQ));
            total++; if (obs_valid !== ev) begin bad++; $display("FAIL uni_valid k=%0d act=%b exp=%b", k, obs_valid, ev); end
            total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL uni_ready k=%0d act=%b exp=1", k, obs_in_ready); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL uni_idle act=%b exp=0", busy); end
        for (int i = 0; i < NQ; i++) begin
            total++;
            if (sent_cnt[i*CW +: CW] !== CW'(exp_cnt(s0[i] + 2))) begin
                bad++; $display("FAIL uni_sent q%0d act=%0d exp=%0d", i, sent_cnt[i*CW +: CW], exp_cnt(s0[i] + 2));
            end
        end
    endtask

    task automatic test_multicast();
        logic [W-1:0] d1, d2;
        d1 = make_phv(4'b1011);
        d2 = make_phv(4'b0100);
        cycle(1, d1, 4'b1111);
        total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL mc_accept act=%b exp=1", obs_in_ready); end
        cycle(0, make_phv(4'b0000), 4'b1110);
        total++; if (obs_valid !== 4'b1011) begin bad++; $display("FAIL mc_valid_t1 act=%b exp=1011", obs_valid); end
        total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL mc_ready_t1 act=%b exp=0", obs_in_ready); end
        total++; if (obs_out !== d1) begin bad++; $display("FAIL mc_data_t1 act=%h exp=%h", obs_out, d1); end
        for (int k = 0; k < 2; k++) begin
            cycle(1, d2, 4'b1110);
            total++; if (obs_valid !== 4'b0001) begin bad++; $display("FAIL mc_valid_skew k=%0d act=%b exp=0001", k, obs_valid); end
            total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL mc_ready_skew k=%0d act=%b exp=0", k, obs_in_ready); end
            total++; if (obs_out !== d1) begin bad++; $display("FAIL mc_stable k=%0d act=%h exp=%h", k, obs_out, d1); end
        end
        cycle(1, d2, 4'b1111);
        total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL mc_exit_ready act=%b exp=1", obs_in_ready); end
        total++; if (obs_valid !== 4'b0001) begin bad++; $display("FAIL mc_exit_valid act=%b exp=0001", obs_valid); end
        cycle(0, '0, 4'b1111);
        total++; if (obs_valid !== 4'b0100 || obs_out !== d2) begin bad++; $display("FAIL mc_next act=%b/%h exp=0100/%h", obs_valid, obs_out, d2); end
        cycle(0, '0, 4'b1111);
        total++; if (obs_valid !== 4'b0000 || obs_busy !== 1'b0) begin bad++; $display("FAIL mc_idle act=%b/%b exp=0000/0", obs_valid, obs_busy); end
    endtask

    task automatic test_zero_bitmap();
        int d0;
        logic [W-1:0] h;
        d0 = m_drop;
        h = make_phv(4'b0001);
        cycle(1, make_phv(4'b0000), 4'b1111);
        total++; if (obs_valid !== '0 || obs_in_ready !== 1'b1) begin bad++; $display("FAIL zb_idle act=%b/%b exp=0000/1", obs_valid, obs_in_ready); end
        cycle(1, h, 4'b0000);
        total++; if (obs_valid !== '0 || obs_busy !== 1'b0) begin bad++; $display("FAIL zb_no_hold act=%b/%b exp=0000/0", obs_valid, obs_busy); end
        cycle(1, make_phv(4'b0000), 4'b0001);
        total++; if (obs_valid !== 4'b0001 || obs_in_ready !== 1'b1) begin bad++; $display("FAIL zb_exit act=%b/%b exp=0001/1", obs_valid, obs_in_ready); end
        cycle(0, '0, 4'b1111);
        total++; if (obs_valid !== '0 || obs_busy !== 1'b0) begin bad++; $display("FAIL zb_after act=%b/%b exp=0000/0", obs_valid, obs_busy); end
        total++; if (obs_out !== h) begin bad++; $display("FAIL zb_held act=%h exp=%h", obs_out, h); end
        total++; if (drop_cnt !== CW'(exp_cnt(d0 + 2))) begin bad++; $display("FAIL zb_drop act=%0d exp=%0d", drop_cnt, exp_cnt(d0 + 2)); end
    endtask

    task automatic test_saturation();
        int guard;
        guard = 0;
        while (m_sent[2] < CMAX - 1 && guard < 2 * CMAX) begin
            cycle(1, make_phv(4'b0100), '1);
            cycle(0, '0, '1);
            guard++;
        end
        total++; if (sent_cnt[2*CW +: CW] !== CW'(exp_cnt(CMAX - 1))) begin bad++; $display("FAIL sat_pre act=%0d exp=%0d", sent_cnt[2*CW +: CW], exp_cnt(CMAX - 1)); end
        for (int k = 0; k < 3; k++) begin
            cycle(1, make_phv(4'b0100), '1);
            cycle(0, '0, '1);
        end
        total++; if (sent_cnt[2*CW +: CW] !== CW'(exp_cnt(CMAX))) begin bad++; $display("FAIL sat_hold act=%0d exp=%0d", sent_cnt[2*CW +: CW], exp_cnt(CMAX)); end
    endtask

    task automatic test_random();
        logic [NQ-1:0] m, r;
        for (int k = 0; k < 300; k++) begin
            m = ($urandom_range(0, 5) == 0) ? '0 : NQ'($urandom_range(1, 15));
            r = ($urandom_range(0, 2) == 0) ? NQ'($urandom_range(0, 15)) : '1;
            cycle($urandom_range(0, 3) != 0, make_phv(m), r);
            total++;
            if (obs_in_ready !== exp_in_ready || obs_valid !== exp_valid || obs_busy !== exp_busy) begin
                bad++; $display("FAIL rnd_ctl k=%0d act=%b/%b/%b exp=%b/%b/%b", k, obs_in_ready, obs_valid, obs_busy, exp_in_ready, exp_valid, exp_busy);
            end
            total++; if (obs_out !== exp_out) begin bad++; $display("FAIL rnd_data k=%0d act=%h exp=%h", k, obs_out, exp_out); end
            total++; if (drop_cnt !== CW'(exp_cnt(m_drop))) begin bad++; $display("FAIL rnd_drop k=%0d act=%0d exp=%0d", k, drop_cnt, exp_cnt(m_drop)); end
            for (int i = 0; i < NQ; i++) begin
                total++;
                if (sent_cnt[i*CW +: CW] !== CW'(exp_cnt(m_sent[i]))) begin
                    bad++; $display("FAIL rnd_sent k=%0d q%0d act=%0d exp=%0d", k, i, sent_cnt[i*CW +: CW], exp_cnt(m_sent[i]));
                end
            end
        end
        cycle(0, '0, '1);
        cycle(0, '0, '1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_flush act=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_hold();
        cycle(1, make_phv(4'b0110), 4'b0000);
        cycle(0, '0, 4'b0000);
        total++; if (obs_valid !== 4'b0110) begin bad++; $display("FAIL rmh_pend act=%b exp=0110", obs_valid); end
        #2;
        reset = 1;
        #1;
        total++; if (out_if.valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rmh_async act=%b/%b exp=0000/0", out_if.valid, busy); end
        model_reset();
        @(posedge axis_clk);
        @(negedge axis_clk);
        reset = 0;
        #1;
        total++; if (in_if.ready[0] !== 1'b0) begin bad++; $display("FAIL rmh_rel_ready act=%b exp=0", in_if.ready[0]); end
        total++; if (drop_cnt !== '0 || sent_cnt !== '0) begin bad++; $display("FAIL rmh_cnt act=%h/%h exp=0", drop_cnt, sent_cnt); end
        @(posedge axis_clk); #1;
        m_live = 1;
        total++; if (in_if.ready[0] !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rmh_first_edge act=%b/%b exp=1/0", in_if.ready[0], busy); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < NQ; i++) begin
            total++;
            if (exp_q[i].size() != 0) begin bad++; $display("FAIL drain q%0d act=%0d exp=0", i, exp_q[i].size()); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unicast();
        test_multicast();
        test_zero_bitmap();
        test_saturation();
        test_random();
        test_reset_mid_hold();
        test_unicast();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
